waiter_state_machine: RTL and testbench

WAITER_STATE_MACHINE -- requirements
Module: waiter_state_machine

---
 rtl/waiter_state_machine.sv | 175 +++++++++++++++++
 tb/tb_waiter_state_machine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waiter_state_machine.sv
// Waiter robot motion FSM: drives direction/speed to the motor driver.
// Optional emergency stop with state save/resume when WAITER_ESTOP_EN is defined.
module waiter_state_machine #(
    parameter int unsigned TURN_CYCLES = 75_000_000,
    parameter int unsigned IDLE_CYCLES = 500_000_000,
    parameter int unsigned BACK_CYCLES = 50_000_000,
    parameter int unsigned RAMP_CYCLES = 5_000_000,
    parameter logic [7:0]  WALL_CM     = 8'd30,
    parameter logic [7:0]  TABLE_CM    = 8'd15,
    parameter logic [7:0]  SLOW_CM     = 8'd50,
    parameter logic [2:0]  MAX_SPEED   = 3'd5,
    parameter logic [2:0]  TURN_SPEED  = 3'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       freq_start,
    input  logic [7:0] dist_cm,
    input  logic       dist_valid,
    input  logic       estop,
    output logic [3:0] direction,
    output logic [2:0] speed,
    output logic       state_change
);
    typedef enum logic [3:0] {
        IDLE_BASE   = 4'd0,
        FORWARDS    = 4'd1,
        TURN        = 4'd2,
        TO_TABLE    = 4'd3,
        IDLE_TABLE  = 4'd4,
        BACKWARDS   = 4'd5,
        TURN_BACK   = 4'd6,
        RETURN_HOME = 4'd7,
        STOP        = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] ramp_tmr_q, ramp_tmr_d;
    logic [2:0]  ramp_q, ramp_d;
    logic [2:0]  speed_q, speed_d;
    logic        near_q, near_d;
    logic        slow_q, slow_d;
    logic        chg_q;
    logic        near_evt;
    logic        near_st;
    logic        ramp_st;
    logic [7:0]  thr;

`ifdef WAITER_ESTOP_EN
    state_t saved_q, saved_d;
`else
    logic unused_estop;
    assign unused_estop = estop;
`endif

    assign near_st = (state_q == FORWARDS) || (state_q == TO_TABLE) || (state_q == RETURN_HOME);
    assign ramp_st = near_st || (state_q == BACKWARDS);
    assign thr     = (state_q == FORWARDS) ? WALL_CM : TABLE_CM;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 32'd1;
        ramp_d     = ramp_q;
        ramp_tmr_d = ramp_tmr_q;
        near_d     = near_q;
        slow_d     = slow_q;
        near_evt   = 1'b0;
        speed_d    = 3'd0;
`ifdef WAITER_ESTOP_EN
        saved_d    = saved_q;
`endif

        if (dist_valid) slow_d = (dist_cm < SLOW_CM);

        // Near detection: second consecutive in-range sample fires the event.
        if (near_st && dist_valid) begin
            if (dist_cm <= thr) begin
                if (near_q) near_evt = 1'b1;
                else        near_d   = 1'b1;
            end else begin
                near_d = 1'b0;
            end
        end

        if (ramp_st) begin
            if (ramp_tmr_q == RAMP_CYCLES - 32'd1) begin
                ramp_tmr_d = 32'd0;
                if (ramp_q < MAX_SPEED) ramp_d = ramp_q + 3'd1;
            end else begin
                ramp_tmr_d = ramp_tmr_q + 32'd1;
            end
        end

        case (state_q)
            IDLE_BASE:   if (freq_start) state_d = FORWARDS;
            FORWARDS:    if (near_evt) state_d = TURN;
            TURN:        if (timer_q == TURN_CYCLES - 32'd1) state_d = TO_TABLE;
            TO_TABLE:    if (near_evt) state_d = IDLE_TABLE;
            IDLE_TABLE:  if (freq_start || (timer_q == IDLE_CYCLES - 32'd1)) state_d = BACKWARDS;
            BACKWARDS:   if (timer_q == BACK_CYCLES - 32'd1) state_d = TURN_BACK;
            TURN_BACK:   if (timer_q == TURN_CYCLES - 32'd1) state_d = RETURN_HOME;
            RETURN_HOME: if (near_evt) state_d = IDLE_BASE;
            STOP:        ;
            default:     state_d = IDLE_BASE;
        endcase

`ifdef WAITER_ESTOP_EN
        // estop overrides any transition decided above
        if (state_q == STOP) begin
            timer_d    = timer_q;
            ramp_d     = ramp_q;
            ramp_tmr_d = ramp_tmr_q;
            if (!estop) state_d = saved_q;
        end else if (estop && (state_q != IDLE_BASE) && (state_q != IDLE_TABLE)) begin
            state_d = STOP;
            saved_d = state_q;
        end
`endif

        if (state_d != state_q) begin
            near_d = 1'b0;
            if (state_d == STOP) begin
                timer_d    = timer_q;
                ramp_d     = ramp_q;
                ramp_tmr_d = ramp_tmr_q;
            end else begin
                // resuming from STOP keeps the dwell timer, ramp always restarts
                if (state_q != STOP) timer_d = 32'd0;
                ramp_d     = 3'd1;
                ramp_tmr_d = 32'd0;
            end
        end

        case (state_d)
            FORWARDS, TO_TABLE, RETURN_HOME:
                speed_d = (slow_d && (ramp_d > 3'd2)) ? 3'd2 : ramp_d;
            BACKWARDS:       speed_d = ramp_d;
            TURN, TURN_BACK: speed_d = TURN_SPEED;
            default:         speed_d = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE_BASE;
            timer_q    <= 32'd0;
            ramp_tmr_q <= 32'd0;
            ramp_q     <= 3'd0;
            speed_q    <= 3'd0;
            near_q     <= 1'b0;
            slow_q     <= 1'b0;
            chg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ramp_tmr_q <= ramp_tmr_d;
            ramp_q     <= ramp_d;
            speed_q    <= speed_d;
            near_q     <= near_d;
            slow_q     <= slow_d;
            chg_q      <= (state_d != state_q);
        end
    end

`ifdef WAITER_ESTOP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) saved_q <= IDLE_BASE;
        else        saved_q <= saved_d;
    end
`endif

    assign direction    = state_q;
    assign speed        = speed_q;
    assign state_change = chg_q;
endmodule

// File: tb/tb_waiter_state_machine.sv
// Bench for waiter_state_machine: directed scenarios plus randomized traffic
// checked every cycle against a dwell/age-based behavioural model.
module tb_waiter_state_machine;
    localparam int TURN = 10, IDLE = 20, BACK = 8, RAMP = 4;
    localparam int WALL = 30, TABLE = 15, SLOW = 50, MAXS = 5, TSPD = 2;

    logic       clk, rst_n, freq_start, dist_valid, estop;
    logic [7:0] dist_cm;
    logic [3:0] direction;
    logic [2:0] speed;
    logic       state_change;

    waiter_state_machine #(
        .TURN_CYCLES(TURN), .IDLE_CYCLES(IDLE), .BACK_CYCLES(BACK), .RAMP_CYCLES(RAMP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .freq_start(freq_start), .dist_cm(dist_cm),
        .dist_valid(dist_valid), .estop(estop), .direction(direction),
        .speed(speed), .state_change(state_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int pulse_cnt = 0;
    int seq[$];
    int cycle_no = 0;

    // inputs as seen by the DUT at each rising edge
    logic s_rst_n, s_fs, s_dv, s_estop, started = 1'b0;
    int   s_dist;
    always @(posedge clk) begin
        s_rst_n <= rst_n;
        s_fs    <= freq_start;
        s_dv    <= dist_valid;
        s_estop <= estop;
        s_dist  <= int'(dist_cm);
        started <= 1'b1;
    end

    // Model: mode number, cycles dwelt, near streak, cycles since (re)entry, last distance
    int m_dir, m_spd, m_chg, m_dwell, m_streak, m_age, m_last, m_saved;

    task automatic model_step();
        int nd, thr, s;
        bit near;
        if (!s_rst_n) begin
            m_dir = 0; m_spd = 0; m_chg = 0; m_dwell = 0;
            m_streak = 0; m_age = 0; m_last = -1; m_saved = 0;
            return;
        end
        if (s_dv) m_last = s_dist;
        thr = (m_dir == 1) ? WALL : TABLE;
        if ((m_dir == 1 || m_dir == 3 || m_dir == 7) && s_dv)
            m_streak = (s_dist <= thr) ? m_streak + 1 : 0;
        near = (m_streak >= 2);
        nd = m_dir;
        case (m_dir)
            0: if (s_fs) nd = 1;
            1: if (near) nd = 2;
            2: if (m_dwell + 1 == TURN) nd = 3;
            3: if (near) nd = 4;
            4: if (s_fs || m_dwell + 1 == IDLE) nd = 5;
            5: if (m_dwell + 1 == BACK) nd = 6;
            6: if (m_dwell + 1 == TURN) nd = 7;
            7: if (near) nd = 0;
            default: ;
        endcase
`ifdef WAITER_ESTOP_EN
        if (m_dir == 8) begin
            if (!s_estop) nd = m_saved;
        end else if (s_estop && m_dir != 0 && m_dir != 4) begin
            nd = 8;
            m_saved = m_dir;
        end
`endif
        if (nd != m_dir) begin
            m_streak = 0;
            if (nd != 8) begin
                if (m_dir != 8) m_dwell = 0;
                m_age = 0;
            end
        end else if (m_dir != 8) begin
            m_dwell++;
            m_age++;
        end
        m_chg = (nd != m_dir) ? 1 : 0;
        m_dir = nd;
        case (m_dir)
            1, 3, 5, 7: begin
                s = 1 + m_age / RAMP;
                if (s > MAXS) s = MAXS;
                if (m_dir != 5 && m_last >= 0 && m_last < SLOW && s > 2) s = 2;
            end
            2, 6:    s = TSPD;
            default: s = 0;
        endcase
        m_spd = s;
    endtask

    initial forever begin
        @(negedge clk);
        cycle_no++;
        if (started) begin
            model_step();
            vectors++;
            if ((^{direction, speed, state_change} === 1'bx) || int'(direction) != m_dir ||
                int'(speed) != m_spd || int'(state_change) != m_chg) begin
                miscompares++;
                $display("FAIL model cycle %0d: dir/spd/chg got %0d/%0d/%0d expected %0d/%0d/%0d",
                         cycle_no, direction, speed, state_change, m_dir, m_spd, m_chg);
            end
            if (state_change === 1'b1) begin
                pulse_cnt++;
                seq.push_back(int'(direction));
            end
        end
    end

    task automatic check(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    task automatic pulse_fs();
        freq_start = 1'b1;
        cyc(1);
        freq_start = 1'b0;
    endtask

    task automatic strobe(int d);
        dist_cm    = 8'(d);
        dist_valid = 1'b1;
        cyc(1);
        dist_valid = 1'b0;
    endtask

    // From IDLE_BASE to the first cycle of RETURN_HOME with literal checkpoints
    task automatic loop_to_home();
        pulse_fs();
        check("fwd dir", int'(direction), 1);
        check("fwd chg", int'(state_change), 1);
        check("fwd spd", int'(speed), 1);
        strobe(20); strobe(20);
        check("turn dir", int'(direction), 2);
        check("turn spd", int'(speed), 2);
        cyc(9);  check("turn dwell", int'(direction), 2);
        cyc(1);  check("to_table dir", int'(direction), 3);
        check("to_table spd", int'(speed), 1);
        pulse_fs();
        check("fs ignored in to_table", int'(direction), 3);
        strobe(10); strobe(10);
        check("idle_table dir", int'(direction), 4);
        check("idle_table spd", int'(speed), 0);
        cyc(19); check("idle dwell", int'(direction), 4);
        cyc(1);  check("back dir", int'(direction), 5);
        cyc(4);  check("back ramp", int'(speed), 2);
        cyc(3);  check("back dwell", int'(direction), 5);
        cyc(1);  check("turn_back dir", int'(direction), 6);
        check("turn_back spd", int'(speed), 2);
        cyc(9);  check("turn_back dwell", int'(direction), 6);
        cyc(1);  check("return dir", int'(direction), 7);
    endtask

    initial begin
        int exp_seq[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
        int base_n, base_q;
        rst_n = 1'b0; freq_start = 1'b0; dist_valid = 1'b0; estop = 1'b0; dist_cm = 8'd0;
        cyc(2);
        check("reset dir", int'(direction), 0);
        check("reset spd", int'(speed), 0);
        check("reset chg", int'(state_change), 0);
        rst_n = 1'b1;
        cyc(1);

        // full delivery loop
        base_n = pulse_cnt; base_q = seq.size();
        loop_to_home();
        strobe(10); strobe(10);
        check("home dir", int'(direction), 0);
        #1;
        check("loop pulses", pulse_cnt - base_n, 8);
        for (int i = 0; i < 8; i++)
            check("loop seq", (seq.size() > base_q + i) ? seq[base_q + i] : -1, exp_seq[i]);

        // reset mid-motion in RETURN_HOME
        cyc(1);
        loop_to_home();
        cyc(5);  check("return capped spd", int'(speed), 2);
        do_reset();
        check("midreset dir", int'(direction), 0);
        check("midreset spd", int'(speed), 0);
        check("midreset chg", int'(state_change), 0);
        pulse_fs();
        check("post-reset fwd", int'(direction), 1);

        // near needs two consecutive in-range samples
        strobe(20); strobe(40); strobe(20);
        check("no turn 20,40,20", int'(direction), 1);
        strobe(20);
        check("turn after 20,20", int'(direction), 2);
        pulse_fs();
        check("fs ignored in turn", int'(direction), 2);

        // speed ramp in FORWARDS
        do_reset();
        pulse_fs();
        check("ramp s1", int'(speed), 1);
        cyc(3);  check("ramp s1 end", int'(speed), 1);
        cyc(1);  check("ramp s2", int'(speed), 2);
        cyc(4);  check("ramp s3", int'(speed), 3);
        cyc(4);  check("ramp s4", int'(speed), 4);
        cyc(4);  check("ramp s5", int'(speed), 5);
        cyc(8);  check("ramp hold", int'(speed), 5);
        strobe(45);
        check("slow cap", int'(speed), 2);
        strobe(60);
        check("cap released", int'(speed), 5);

        // freq_start in IDLE_TABLE at dwell cycle 5
        do_reset();
        pulse_fs(); strobe(20); strobe(20); cyc(10); strobe(10); strobe(10);
        check("idle reach", int'(direction), 4);
        cyc(5);
        freq_start = 1'b1; cyc(1); freq_start = 1'b0;
        check("fs early back", int'(direction), 5);

        // freq_start coinciding with the IDLE_TABLE timeout
        do_reset();
        pulse_fs(); strobe(20); strobe(20); cyc(10); strobe(10); strobe(10);
        cyc(19);
        freq_start = 1'b1; cyc(1); freq_start = 1'b0;
        check("coincide dir", int'(direction), 5);
        check("coincide chg", int'(state_change), 1);
        cyc(1);
        check("coincide once", int'(state_change), 0);

        // estop during TURN
        do_reset();
        pulse_fs(); strobe(20); strobe(20);
        cyc(4);
        estop = 1'b1;
        cyc(1);
`ifdef WAITER_ESTOP_EN
        check("estop dir", int'(direction), 8);
        check("estop spd", int'(speed), 0);
        cyc(5);
        estop = 1'b0;
        check("estop held", int'(direction), 8);
        cyc(1);  check("resume dir", int'(direction), 2);
        cyc(5);  check("resume dwell", int'(direction), 2);
        cyc(1);  check("resume exit", int'(direction), 3);
`else
        check("estop ignored", int'(direction), 2);
        cyc(4);  check("turn on schedule", int'(direction), 2);
        cyc(1);
        estop = 1'b0;
        check("turn exit sched", int'(direction), 3);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst_n      = ($urandom_range(0, 399) != 0);
            freq_start = ($urandom_range(0, 15) == 0);
            dist_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0, 1:    dist_cm = 8'($urandom_range(0, 17));
                2:       dist_cm = 8'($urandom_range(27, 33));
                3:       dist_cm = 8'($urandom_range(47, 53));
                default: dist_cm = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 39) == 0) estop = ~estop;
            cyc(1);
        end
        rst_n = 1'b1; freq_start = 1'b0; dist_valid = 1'b0; estop = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
